// File: rtl/ipg_msg_arbiter.sv
// Message-granular grant scheduler for one output vport: IDLE/BUSY grant FSM, per-type
// round-robin port pointers, rresp/wreq starvation promotion and gap-timeout release.
module ipg_msg_arbiter #(
    parameter int PORT_NUM     = 4,
    parameter int PORT_W       = $clog2(PORT_NUM),
    parameter int STARVE_LIMIT = 8,
    parameter int GAP_LIMIT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PORT_NUM-1:0] rreq_pend,
    input  logic [PORT_NUM-1:0] rresp_pend,
    input  logic [PORT_NUM-1:0] wreq_pend,
    input  logic                tx_ready,
    input  logic                fire_last,
    output logic [PORT_NUM-1:0] fire_en,
    output logic [1:0]          fire_type_sel,
    output logic [PORT_W-1:0]   grant_port,
    output logic                tx_ipg_en,
    output logic                abort
);
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    localparam logic [1:0]        T_RREQ   = 2'd0;
    localparam logic [1:0]        T_RRESP  = 2'd1;
    localparam logic [1:0]        T_WREQ   = 2'd2;
    localparam logic [1:0]        T_NONE   = 2'd3;
    localparam logic [7:0]        SC_MAX   = 8'(STARVE_LIMIT);
    localparam logic [7:0]        GAP_LAST = 8'(GAP_LIMIT - 1);
    localparam logic [PORT_W-1:0] PTR_INIT = PORT_W'(PORT_NUM - 1);

    state_t              state_q, state_d;
    logic [1:0]          g_type_q, g_type_d;
    logic [PORT_W-1:0]   g_port_q, g_port_d;
    logic [PORT_W-1:0]   ptr_q [3];
    logic [PORT_W-1:0]   ptr_d [3];
    logic [7:0]          sc1_q, sc1_d;
    logic [7:0]          sc2_q, sc2_d;
    logic [7:0]          gap_q, gap_d;

    logic [PORT_NUM-1:0] g_vec, sel_vec;
    logic                g_pend, busy, xfer, any_pend, found;
    logic [1:0]          sel_type;
    logic [PORT_W-1:0]   sel_ptr, sel_port, idx;

    assign busy     = (state_q == ST_BUSY);
    assign any_pend = |{rreq_pend, rresp_pend, wreq_pend};

    always_comb begin
        g_vec = '0;
        case (g_type_q)
            T_RREQ:  g_vec = rreq_pend;
            T_RRESP: g_vec = rresp_pend;
            T_WREQ:  g_vec = wreq_pend;
            default: g_vec = '0;
        endcase
    end

    assign g_pend        = g_vec[g_port_q];
    assign xfer          = busy & tx_ready & g_pend;
    assign abort         = busy & ~g_pend & (gap_q == GAP_LAST);
    assign tx_ipg_en     = xfer;
    assign fire_en       = xfer ? (PORT_NUM'(1) << g_port_q) : '0;
    assign fire_type_sel = busy ? g_type_q : T_NONE;
    assign grant_port    = g_port_q;

    // Promoted types win over the fixed rreq > rresp > wreq order.
    always_comb begin
        if ((sc2_q == SC_MAX) && (|wreq_pend))       sel_type = T_WREQ;
        else if ((sc1_q == SC_MAX) && (|rresp_pend)) sel_type = T_RRESP;
        else if (|rreq_pend)                         sel_type = T_RREQ;
        else if (|rresp_pend)                        sel_type = T_RRESP;
        else                                         sel_type = T_WREQ;
    end

    always_comb begin
        sel_vec = rreq_pend;
        sel_ptr = ptr_q[0];
        case (sel_type)
            T_RRESP: begin sel_vec = rresp_pend; sel_ptr = ptr_q[1]; end
            T_WREQ:  begin sel_vec = wreq_pend;  sel_ptr = ptr_q[2]; end
            default: begin sel_vec = rreq_pend;  sel_ptr = ptr_q[0]; end
        endcase
    end

    // Search starts one past the last winner; the last winner itself is tried last.
    always_comb begin
        sel_port = sel_ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= PORT_NUM; k++) begin
            idx = PORT_W'((int'(sel_ptr) + k) % PORT_NUM);
            if (!found && sel_vec[idx]) begin
                sel_port = idx;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        g_type_d = g_type_q;
        g_port_d = g_port_q;
        ptr_d    = ptr_q;
        sc1_d    = sc1_q;
        sc2_d    = sc2_q;
        gap_d    = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (any_pend) begin
                    state_d  = ST_BUSY;
                    g_type_d = sel_type;
                    g_port_d = sel_port;
                    gap_d    = '0;
                    case (sel_type)
                        T_RRESP: begin ptr_d[1] = sel_port; sc1_d = '0; end
                        T_WREQ:  begin ptr_d[2] = sel_port; sc2_d = '0; end
                        default: ptr_d[0] = sel_port;
                    endcase
                end
            end
            ST_BUSY: begin
                if (xfer) begin
                    gap_d = '0;
                    if (fire_last) begin
                        state_d = ST_IDLE;
                        if ((g_type_q != T_RRESP) && (|rresp_pend) && (sc1_q < SC_MAX))
                            sc1_d = sc1_q + 8'd1;
                        if ((g_type_q != T_WREQ) && (|wreq_pend) && (sc2_q < SC_MAX))
                            sc2_d = sc2_q + 8'd1;
                    end
                end else if (!g_pend) begin
                    // A stalled tx_ready with data present never reaches this branch.
                    if (abort) state_d = ST_IDLE;
                    else       gap_d   = gap_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            g_type_q <= T_RREQ;
            g_port_q <= '0;
            for (int i = 0; i < 3; i++) ptr_q[i] <= PTR_INIT;
            sc1_q    <= '0;
            sc2_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            g_type_q <= g_type_d;
            g_port_q <= g_port_d;
            ptr_q    <= ptr_d;
            sc1_q    <= sc1_d;
            sc2_q    <= sc2_d;
            gap_q    <= gap_d;
        end
    end
endmodule

// File: tb/tb_ipg_msg_arbiter.sv
// Directed scenarios plus a randomized run scored against a message-queue model of the arbiter.
module tb_ipg_msg_arbiter;
    localparam int PN = 4;
    localparam int PW = 2;
    localparam int SL = 2;
    localparam int GL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PN-1:0] rreq_pend = '0, rresp_pend = '0, wreq_pend = '0;
    logic          tx_ready = 1'b0, fire_last = 1'b0;
    logic [PN-1:0] fire_en;
    logic [1:0]    fire_type_sel;
    logic [PW-1:0] grant_port;
    logic          tx_ipg_en, abort;

    ipg_msg_arbiter #(.PORT_NUM(PN), .PORT_W(PW), .STARVE_LIMIT(SL), .GAP_LIMIT(GL)) dut (
        .clk(clk), .rst(rst),
        .rreq_pend(rreq_pend), .rresp_pend(rresp_pend), .wreq_pend(wreq_pend),
        .tx_ready(tx_ready), .fire_last(fire_last),
        .fire_en(fire_en), .fire_type_sel(fire_type_sel), .grant_port(grant_port),
        .tx_ipg_en(tx_ipg_en), .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PN-1:0] fe;
        logic [1:0]    sel;
        logic [PW-1:0] gp;
        logic          tx;
        logic          ab;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model: per-queue message counts and head-message remaining words.
    int            nmsg[3][PN];
    int            head_rem[3][PN];
    int            hide[3][PN];
    logic [PN-1:0] pv[3];
    int            m_busy, m_type, m_port, m_empty;
    int            m_last[3];
    int            m_wait[3];

    function automatic obs_t obs_now();
        obs_t o;
        o = {fire_en, fire_type_sel, grant_port, tx_ipg_en, abort};
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic chk(input string name, input logic [PN-1:0] fe, input logic [1:0] sel,
                       input logic tx, input logic ab);
        check(name, 32'({fire_en, fire_type_sel, tx_ipg_en, abort}), 32'({fe, sel, tx, ab}));
    endtask

    task automatic tick(input logic [PN-1:0] rq, input logic [PN-1:0] rs, input logic [PN-1:0] wq,
                        input logic rdy, input logic lst);
        @(posedge clk); #1;
        rreq_pend = rq; rresp_pend = rs; wreq_pend = wq; tx_ready = rdy; fire_last = lst;
        #1;
    endtask

    task automatic do_reset();
        rreq_pend = '0; rresp_pend = '0; wreq_pend = '0; tx_ready = 1'b0; fire_last = 1'b0;
        rst = 1'b1;
        @(posedge clk); #2;
        chk("rst_out", 4'b0000, 2'd3, 1'b0, 1'b0);
        check("rst_gp", 32'(grant_port), 32'd0);
        rst = 1'b0;
    endtask

    task automatic run_monitor();
        obs_t got, want;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                got = obs_now();
                if (got.tx || got.ab) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got 0x%0h, expected no event", got);
                    end else begin
                        want = exp_q.pop_front();
                        check("sb_event", 32'(got), 32'(want));
                    end
                end else if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    check("sb_missing", 32'(got), 32'(want));
                end
            end
        end
    endtask

    task automatic model_cycle();
        logic rdy, lst, have;
        int   t_sel, p_sel, pi;
        obs_t o;
        for (int t = 0; t < 3; t++) begin
            for (int p = 0; p < PN; p++) begin
                if (hide[t][p] > 0) hide[t][p]--;
                else if ($urandom_range(0, 99) < 3) hide[t][p] = int'($urandom_range(1, 7));
                if (nmsg[t][p] < 3 && $urandom_range(0, 99) < 4) begin
                    if (nmsg[t][p] == 0) head_rem[t][p] = int'($urandom_range(1, 4));
                    nmsg[t][p]++;
                end
                pv[t][p] = (nmsg[t][p] > 0) && (hide[t][p] == 0);
            end
        end
        rdy = ($urandom_range(0, 99) < 80);
        lst = (m_busy != 0) ? (head_rem[m_type][m_port] == 1) : 1'($urandom_range(0, 1));
        rreq_pend = pv[0]; rresp_pend = pv[1]; wreq_pend = pv[2];
        tx_ready = rdy; fire_last = lst;

        if (m_busy == 0) begin
            if ((pv[0] | pv[1] | pv[2]) != 0) begin
                if (m_wait[2] == SL && pv[2] != 0)      t_sel = 2;
                else if (m_wait[1] == SL && pv[1] != 0) t_sel = 1;
                else if (pv[0] != 0)                    t_sel = 0;
                else if (pv[1] != 0)                    t_sel = 1;
                else                                    t_sel = 2;
                p_sel = -1;
                for (int k = 1; k <= PN; k++) begin
                    pi = (m_last[t_sel] + k) % PN;
                    if (p_sel < 0 && pv[t_sel][pi]) p_sel = pi;
                end
                m_busy = 1; m_type = t_sel; m_port = p_sel;
                m_last[t_sel] = p_sel; m_wait[t_sel] = 0; m_empty = 0;
            end
        end else begin
            have = pv[m_type][m_port];
            if (rdy && have) begin
                o = '0;
                o.fe = PN'(1 << m_port); o.sel = 2'(m_type); o.gp = PW'(m_port); o.tx = 1'b1;
                exp_q.push_back(o);
                m_empty = 0;
                head_rem[m_type][m_port]--;
                if (head_rem[m_type][m_port] == 0) begin
                    nmsg[m_type][m_port]--;
                    if (nmsg[m_type][m_port] > 0) head_rem[m_type][m_port] = int'($urandom_range(1, 4));
                    m_busy = 0;
                    for (int u = 1; u < 3; u++)
                        if (u != m_type && pv[u] != 0 && m_wait[u] < SL) m_wait[u]++;
                end
            end else if (!have) begin
                m_empty++;
                if (m_empty == GL) begin
                    o = '0;
                    o.sel = 2'(m_type); o.gp = PW'(m_port); o.ab = 1'b1;
                    exp_q.push_back(o);
                    m_busy = 0;
                end
            end
        end
    endtask

    initial begin
        fork run_monitor(); join_none

        // Single 3-word rreq message on port 0, then a re-grant after the arbitration cycle.
        do_reset();
        tick(4'b0001, 4'b0, 4'b0, 1'b1, 1'b0); chk("a_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick(4'b0001, 4'b0, 4'b0, 1'b1, 1'b0); chk("a_w1", 4'b0001, 2'd0, 1'b1, 1'b0);
        check("a_gp", 32'(grant_port), 32'd0);
        tick(4'b0001, 4'b0, 4'b0, 1'b1, 1'b0); chk("a_w2", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(4'b0001, 4'b0, 4'b0, 1'b1, 1'b1); chk("a_w3", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(4'b0001, 4'b0, 4'b0, 1'b1, 1'b0); chk("a_arb", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick(4'b0001, 4'b0, 4'b0, 1'b1, 1'b1); chk("a_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Round robin between ports 0 and 2.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(4'b0101, 4'b0, 4'b0, 1'b1, 1'b1); chk("rr_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
            tick(4'b0101, 4'b0, 4'b0, 1'b1, 1'b1);
            chk("rr_busy", (i % 2 == 0) ? 4'b0001 : 4'b0100, 2'd0, 1'b1, 1'b0);
            check("rr_port", 32'(grant_port), 32'((i % 2) * 2));
        end

        // Starvation promotion of wreq after two completed rreq messages.
        do_reset();
        tick(4'b0001, 4'b0, 4'b0010, 1'b1, 1'b1); chk("sv_idle0", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick(4'b0001, 4'b0, 4'b0010, 1'b1, 1'b1); chk("sv_rreq0", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(4'b0001, 4'b0, 4'b0010, 1'b1, 1'b1); chk("sv_idle1", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick(4'b0001, 4'b0, 4'b0010, 1'b1, 1'b1); chk("sv_rreq1", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(4'b0001, 4'b0, 4'b0010, 1'b1, 1'b1); chk("sv_idle2", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick(4'b0001, 4'b0, 4'b0010, 1'b1, 1'b1); chk("sv_wreq", 4'b0010, 2'd2, 1'b1, 1'b0);
        check("sv_wreq_gp", 32'(grant_port), 32'd1);
        tick(4'b0001, 4'b0, 4'b0, 1'b1, 1'b1); chk("sv_idle3", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick(4'b0001, 4'b0, 4'b0, 1'b1, 1'b1); chk("sv_rreq2", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Gap timeout on rresp port 3.
        do_reset();
        tick(4'b0, 4'b1000, 4'b0, 1'b1, 1'b0); chk("gap_idle0", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick(4'b0, 4'b1000, 4'b0, 1'b1, 1'b0); chk("gap_word", 4'b1000, 2'd1, 1'b1, 1'b0);
        for (int i = 1; i <= GL - 1; i++) begin
            tick(4'b0, 4'b0, 4'b0, 1'b1, 1'b0); chk("gap_wait", 4'b0000, 2'd1, 1'b0, 1'b0);
        end
        tick(4'b0, 4'b0, 4'b0, 1'b1, 1'b0); chk("gap_abort", 4'b0000, 2'd1, 1'b0, 1'b1);
        tick(4'b0, 4'b0, 4'b0, 1'b1, 1'b0); chk("gap_idle1", 4'b0000, 2'd3, 1'b0, 1'b0);

        // tx_ready stall with data present holds the grant without timing out.
        do_reset();
        tick(4'b0010, 4'b0, 4'b0, 1'b1, 1'b0); chk("st_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick(4'b0010, 4'b0, 4'b0, 1'b1, 1'b0); chk("st_w1", 4'b0010, 2'd0, 1'b1, 1'b0);
        repeat (20) begin
            tick(4'b0010, 4'b0, 4'b0, 1'b0, 1'b1); chk("st_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        tick(4'b0010, 4'b0, 4'b0, 1'b1, 1'b1); chk("st_resume", 4'b0010, 2'd0, 1'b1, 1'b0);
        check("st_gp", 32'(grant_port), 32'd1);
        tick(4'b0, 4'b0, 4'b0, 1'b1, 1'b0); chk("st_end", 4'b0000, 2'd3, 1'b0, 1'b0);

        // Asynchronous reset mid-message, then pointers back at their reset value.
        do_reset();
        tick(4'b0010, 4'b0, 4'b0, 1'b1, 1'b0);
        tick(4'b0010, 4'b0, 4'b0, 1'b1, 1'b0); chk("ar_w1", 4'b0010, 2'd0, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("ar_w2", 4'b0010, 2'd0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 chk("ar_async", 4'b0000, 2'd3, 1'b0, 1'b0);
        check("ar_gp", 32'(grant_port), 32'd0);
        rreq_pend = '0; tx_ready = 1'b0; fire_last = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        tick(4'b0111, 4'b0, 4'b0, 1'b1, 1'b1); chk("ar_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick(4'b0111, 4'b0, 4'b0, 1'b1, 1'b1); chk("ar_first", 4'b0001, 2'd0, 1'b1, 1'b0);
        check("ar_first_gp", 32'(grant_port), 32'd0);

        // Randomized traffic against the queue model.
        do_reset();
        for (int t = 0; t < 3; t++) begin
            m_last[t] = PN - 1;
            m_wait[t] = 0;
            for (int p = 0; p < PN; p++) begin
                nmsg[t][p] = 0; head_rem[t][p] = 0; hide[t][p] = 0;
            end
        end
        m_busy = 0; m_type = 0; m_port = 0; m_empty = 0;
        mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            model_cycle();
        end
        @(negedge clk); #1;
        mon_en = 1'b0;
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
